// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter that lets one of NREQ requesters at a time burst
// payload beats into a shared FIFO, tagging every word with the requester id.
// A grant ends on the requester's last beat, after BURST beats, or after
// STALL_MAX consecutive cycles in which the granted requester has no data.

// Per-requester datapath slice: gates ready/enqueue/payload by the grant.
module fifo_enq_arbiter_lane #(
  parameter int DSIZE = 11
) (
  input  logic             sel,
  input  logic             full_n,
  input  logic             valid,
  input  logic [DSIZE-1:0] data,
  output logic             ready,
  output logic             enq,
  output logic [DSIZE-1:0] payload
);

  // Only the granted lane may see ready or contribute to the FIFO word.
  assign ready   = sel & full_n;
  assign enq     = sel & valid & full_n;
  assign payload = sel ? data : '0;

endmodule

module fifo_enq_arbiter #(
  parameter int DSIZE     = 11,
  parameter int NREQ      = 4,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 8,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full_n,
  output logic                  fifo_enq,
  output logic [DSIZE+IDW-1:0]  fifo_din,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  // Elaboration-time parameter sanity.
  if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0) begin : g_bad_nreq
    $error("NREQ must be a power of two in 2..8");
  end
  if (BURST < 1 || BURST > 16) begin : g_bad_burst
    $error("BURST must be in 1..16");
  end
  if (STALL_MAX < 1 || STALL_MAX > 255) begin : g_bad_stall
    $error("STALL_MAX must be in 1..255");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  grant_nxt;
  logic [IDW-1:0]  last_ptr, last_ptr_nxt;
  logic [3:0]      beat_cnt, beat_nxt;
  logic [7:0]      stall_cnt, stall_nxt;

  logic [IDW-1:0]  pick, scan;
  logic            pick_ok;
  logic            active;
  logic            cur_valid, cur_last;
  logic [4:0]      beat_inc;
  logic [8:0]      stall_inc;

  logic [NREQ-1:0]             lane_sel, lane_enq;
  logic [NREQ-1:0][DSIZE-1:0]  data_vec, lane_payload;
  logic [DSIZE-1:0]            payload_mux;

  // Outputs are forced quiet while reset is asserted so an aborted burst
  // cannot push one more word in the reset cycle itself.
  assign active    = (state == GRANT) & ~rst;
  assign busy      = (state == GRANT);
  assign data_vec  = req_data;
  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign beat_inc  = {1'b0, beat_cnt} + 5'd1;
  assign stall_inc = {1'b0, stall_cnt} + 9'd1;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_sel[i] = active & (grant_id == IDW'(i));
    fifo_enq_arbiter_lane #(.DSIZE(DSIZE)) u_lane (
      .sel     (lane_sel[i]),
      .full_n  (fifo_full_n),
      .valid   (req_valid[i]),
      .data    (data_vec[i]),
      .ready   (req_ready[i]),
      .enq     (lane_enq[i]),
      .payload (lane_payload[i])
    );
  end

  // At most one lane is selected, so OR-reduction acts as the payload mux.
  always_comb begin
    payload_mux = '0;
    for (int i = 0; i < NREQ; i++) payload_mux = payload_mux | lane_payload[i];
  end

  assign fifo_enq = |lane_enq;
  assign fifo_din = active ? {grant_id, payload_mux} : '0;

  // Round-robin search starting just after the last released requester;
  // scanning farthest-first lets the nearest valid requester win.
  always_comb begin
    pick    = last_ptr;
    pick_ok = 1'b0;
    scan    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan = last_ptr + IDW'(k);
      if (req_valid[scan]) begin
        pick    = scan;
        pick_ok = 1'b1;
      end
    end
  end

  // Next-state: arbitrate in IDLE; count beats/stalls and decide release in GRANT.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_id;
    last_ptr_nxt = last_ptr;
    beat_nxt     = beat_cnt;
    stall_nxt    = stall_cnt;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = GRANT;
          grant_nxt = pick;
          beat_nxt  = '0;
          stall_nxt = '0;
        end
      end
      GRANT: begin
        if (fifo_enq) begin
          beat_nxt  = beat_inc[3:0];
          stall_nxt = '0;
          if (cur_last || beat_inc == 5'(BURST)) begin
            state_nxt    = IDLE;
            last_ptr_nxt = grant_id;
          end
        end else if (cur_valid) begin
          // Data present but FIFO full: backpressure, not a stall.
          stall_nxt = '0;
        end else if (stall_inc >= 9'(STALL_MAX)) begin
          state_nxt    = IDLE;
          last_ptr_nxt = grant_id;
          stall_nxt    = '0;
        end else begin
          stall_nxt = stall_inc[7:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset leaves requester 0 first in round-robin order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      last_ptr  <= IDW'(NREQ - 1);
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      last_ptr  <= last_ptr_nxt;
      beat_cnt  <= beat_nxt;
      stall_cnt <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed-vector and scoreboard bench for fifo_enq_arbiter (default parameters).
module tb_fifo_enq_arbiter;

  localparam int DSIZE     = 11;
  localparam int NREQ      = 4;
  localparam int BURST     = 4;
  localparam int STALL_MAX = 8;
  localparam int IDW       = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full_n = 1'b1;
  logic                  fifo_enq;
  logic [DSIZE+IDW-1:0]  fifo_din;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fifo_enq_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full_n(fifo_full_n), .fifo_enq(fifo_enq),
    .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic       c;
    logic       busy;
    logic [1:0] gid;
    logic       enq;
    logic [3:0] rdy;
  } vec_t;

  typedef struct packed {
    logic [DSIZE-1:0] data;
    logic             last;
  } beat_t;

  vec_t             tbl[$];
  beat_t            src_q[NREQ][$];
  logic [DSIZE-1:0] exp_q[NREQ][$];
  logic             log_enq[$];
  logic             log_busy[$];
  logic [IDW-1:0]   log_tag[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic addv(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                      input logic c, input logic b, input logic [1:0] g, input logic e,
                      input logic [3:0] rd);
    vec_t x;
    x.rst = r; x.v = v; x.l = l; x.f = f; x.c = c;
    x.busy = b; x.gid = g; x.enq = e; x.rdy = rd;
    tbl.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Queue-driven sources plus scoreboard; one iteration per clock cycle.
  task automatic run_src(input int ncyc, input bit rnd, input bit gen, input bit stop_empty);
    logic [IDW-1:0] t;
    for (int c = 0; c < ncyc; c++) begin
      if (stop_empty && all_empty()) break;
      if (gen) begin
        for (int i = 0; i < NREQ; i++) begin
          if (src_q[i].size() < 4 && $urandom_range(1, 0) == 1) begin
            beat_t b;
            b.data = DSIZE'($urandom);
            b.last = ($urandom_range(2, 0) == 0);
            src_q[i].push_back(b);
            exp_q[i].push_back(b.data);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (src_q[i].size() > 0) && (!rnd || $urandom_range(3, 0) != 0);
        req_data[i*DSIZE +: DSIZE] = (src_q[i].size() > 0) ? src_q[i][0].data : '0;
        req_last[i] = (src_q[i].size() > 0) && src_q[i][0].last;
      end
      fifo_full_n = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      #3;
      chk("no_enq_when_full", 32'(fifo_enq & ~fifo_full_n), 32'd0);
      chk("handshake_vs_enq", 32'(|(req_valid & req_ready)), 32'(fifo_enq));
      log_enq.push_back(fifo_enq);
      log_busy.push_back(busy);
      t = fifo_din[DSIZE +: IDW];
      log_tag.push_back(t);
      if (fifo_enq) begin
        if (exp_q[t].size() == 0) chk("sb_unexpected_word", 32'd1, 32'd0);
        else chk($sformatf("sb_payload_tag%0d", t), 32'(fifo_din[DSIZE-1:0]), 32'(exp_q[t].pop_front()));
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] onehot;
    logic [1:0] idle_gid;
    logic       expd;

    // Row fields: rst, valid, last, full_n, check, busy, grant_id, enq, ready
    addv(0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 4'h0);                  // reset state
    // All four valid, 2-beat bursts: grants 0,1,2,3,0
    for (int q = 0; q < 5; q++) begin
      onehot   = 4'(1 << (q % 4));
      idle_gid = (q == 0) ? 2'd0 : 2'(q - 1);
      addv(0, 4'hF, 4'h0, 1, 1, 0, idle_gid, 0, 4'h0);
      addv(0, 4'hF, 4'h0, 1, 1, 1, 2'(q % 4), 1, onehot);
      addv(0, 4'hF, 4'hF, 1, 1, 1, 2'(q % 4), 1, onehot);
    end
    // Backpressure on requester 1 longer than STALL_MAX: no release
    addv(0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 4'h0);
    addv(0, 4'h2, 4'h0, 1, 1, 0, 0, 0, 4'h0);
    for (int k = 0; k < 10; k++) addv(0, 4'h2, 4'h0, 0, 1, 1, 1, 0, 4'h0);
    addv(0, 4'h2, 4'h2, 1, 1, 1, 1, 1, 4'h2);
    // Requester 3 granted then idles STALL_MAX cycles: release on the 8th
    addv(0, 4'h8, 4'h0, 1, 1, 0, 1, 0, 4'h0);
    for (int k = 0; k < STALL_MAX; k++) addv(0, 4'h0, 4'h0, 1, 1, 1, 3, 0, 4'h8);
    addv(0, 4'h0, 4'h0, 1, 1, 0, 3, 0, 4'h0);
    // last_ptr=3 after stall release: next search starts at 0 -> 1 wins
    addv(0, 4'h6, 4'h0, 1, 1, 0, 3, 0, 4'h0);
    addv(0, 4'h6, 4'h2, 1, 1, 1, 1, 1, 4'h2);
    // Grant 2, reset on its second beat; afterwards requester 0 wins
    addv(0, 4'h6, 4'h0, 1, 1, 0, 1, 0, 4'h0);
    addv(0, 4'h6, 4'h0, 1, 1, 1, 2, 1, 4'h4);
    addv(1, 4'h6, 4'h0, 1, 0, 0, 0, 0, 4'h0);
    addv(0, 4'hF, 4'h0, 1, 1, 0, 0, 0, 4'h0);
    addv(0, 4'hF, 4'h0, 1, 1, 1, 0, 1, 4'h1);

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      logic [DSIZE+IDW-1:0] ed;
      rst         = tbl[r].rst;
      req_valid   = tbl[r].v;
      req_last    = tbl[r].l;
      fifo_full_n = tbl[r].f;
      req_data    = {11'h0A3, 11'h0A2, 11'h0A1, 11'h0A0};
      #3;
      if (tbl[r].c) begin
        ed = tbl[r].busy ? {tbl[r].gid, 11'h0A0 + 11'(tbl[r].gid)} : '0;
        chk($sformatf("row%0d_busy", r),  32'(busy),      32'(tbl[r].busy));
        chk($sformatf("row%0d_gid", r),   32'(grant_id),  32'(tbl[r].gid));
        chk($sformatf("row%0d_enq", r),   32'(fifo_enq),  32'(tbl[r].enq));
        chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
        chk($sformatf("row%0d_din", r),   32'(fifo_din),  32'(ed));
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Requester 2 alone, 6 beats without last: 4 beats, one IDLE cycle, 2 beats
    do_reset();
    log_enq.delete(); log_busy.delete(); log_tag.delete();
    for (int k = 0; k < 6; k++) begin
      beat_t b;
      b.data = 11'h200 + 11'(k);
      b.last = 1'b0;
      src_q[2].push_back(b);
      exp_q[2].push_back(b.data);
    end
    run_src(12, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      expd = (c >= 1 && c <= 4) || c == 6 || c == 7;
      chk($sformatf("burst_cap_enq_c%0d", c), 32'(log_enq[c]), 32'(expd));
      if (expd) chk($sformatf("burst_cap_tag_c%0d", c), 32'(log_tag[c]), 32'd2);
    end
    chk("burst_cap_idle_first", 32'(log_busy[0]), 32'd0);
    chk("burst_cap_idle_gap", 32'(log_busy[5]), 32'd0);
    chk("burst_cap_left_tag2", 32'(exp_q[2].size()), 32'd0);

    // Random valid/last/full_n traffic, then drain with everything open
    do_reset();
    for (int i = 0; i < NREQ; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    run_src(10000, 1'b1, 1'b1, 1'b0);
    run_src(3000, 1'b0, 1'b0, 1'b1);
    chk("drain_done", 32'(all_empty()), 32'd1);
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("sb_leftover_tag%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_enq_arbiter.md
FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

Interface
REQ-001 Parameter DSIZE, default 11: payload width per requester.
REQ-002 Parameter NREQ, default 4: number of requesters (power of 2, 2..8).
REQ-003 Parameter BURST, default 4: maximum beats per grant (1..16).
REQ-004 Parameter STALL_MAX, default 8: consecutive idle cycles tolerated inside a grant (1..255).
REQ-005 Derived IDW = clog2(NREQ); FIFO word width DSIZE+IDW.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 req_valid  input  NREQ  per-requester data valid.
REQ-009 req_data  input  NREQ*DSIZE  packed payloads; requester i at bits [i*DSIZE +: DSIZE].
REQ-010 req_last  input  NREQ  marks the final beat of a requester's burst.
REQ-011 req_ready  output  NREQ  per-requester accept; a beat transfers when valid and ready are both high.
REQ-012 fifo_full_n  input  1  FIFO write side not full (active-high space available).
REQ-013 fifo_enq  output  1  FIFO enqueue strobe.
REQ-014 fifo_din  output  DSIZE+IDW  {grant_id, payload} written to the FIFO.
REQ-015 grant_id  output  IDW  currently granted requester, registered.
REQ-016 busy  output  1  high in GRANT state.

Function
REQ-017 The FSM SHALL have two states: IDLE and GRANT.
REQ-018 In IDLE, when any req_valid is high, the block SHALL select the first valid requester searching round-robin from (last_ptr+1) mod NREQ upward, register it into grant_id, and enter GRANT on the next edge.
REQ-019 Arbitration latency SHALL be exactly 1 cycle from the IDLE-cycle valid to the first cycle in which req_ready can assert.
REQ-020 In IDLE, req_ready SHALL be all-zero and fifo_enq SHALL be 0.
REQ-021 In GRANT, req_ready[grant_id] SHALL equal fifo_full_n; all other req_ready bits SHALL be 0.
REQ-022 fifo_enq SHALL equal req_valid[grant_id] AND fifo_full_n in GRANT (combinational); fifo_din SHALL equal {grant_id, req_data[grant_id]} in GRANT and 0 in IDLE.
REQ-023 fifo_enq SHALL never assert while fifo_full_n is 0.
REQ-024 A 4-bit beat counter SHALL clear on grant entry and increment on each transfer.
REQ-025 GRANT SHALL release to IDLE after a transfer with req_last[grant_id]=1 or after the BURST-th transfer, whichever occurs first; last_ptr SHALL load grant_id on release.
REQ-026 A stall counter SHALL count consecutive GRANT cycles with req_valid[grant_id]=0, clearing on any cycle that valid is high; on reaching STALL_MAX the block SHALL release to IDLE without a transfer.
REQ-027 Cycles with valid high and fifo_full_n low SHALL NOT increment the stall counter (backpressure is not a stall).
REQ-028 No IDLE bubble is skipped: after release, at least one IDLE cycle SHALL occur before the next grant.
REQ-029 Payload SHALL pass through unmodified; no beat is dropped or duplicated.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, grant_id=0, last_ptr=NREQ-1, beat and stall counters=0; hence req_ready=0, fifo_enq=0, fifo_din=0, busy=0 in the following cycle.
REQ-031 Reset asserted mid-burst SHALL abort the grant immediately with no further enqueue; after deassertion requester 0 has first priority.

Verification
REQ-032 Reset, then req_valid=4'b1111 held, each requester bursts 2 beats with req_last on beat 2, fifo_full_n=1 -> grants in order 0,1,2,3,0; fifo_din tag field matches each grant.
REQ-033 Requester 2 valid with no req_last, 6 beats queued, BURST=4 -> 4 enqueues tagged 2, release, 1 IDLE cycle, regrant to 2 (sole requester), remaining 2 beats enqueued.
REQ-034 Grant to requester 1, fifo_full_n=0 for 5 cycles with valid high -> fifo_enq=0, req_ready=0, no release, stall counter stays 0; on fifo_full_n=1 beat enqueues.
REQ-035 Grant to requester 3, valid drops for STALL_MAX=8 cycles -> release to IDLE on cycle 8, no enqueue, last_ptr=3.
REQ-036 rst pulsed during beat 2 of a 4-beat burst -> no enqueue in the cycle after reset, busy=0; next grant with all valid goes to requester 0.
REQ-037 Scoreboard: random valid/last/full_n over 10000 cycles, per-requester queue -> every payload appears exactly once in FIFO order per tag.
